// File: rtl/simon_pkg.sv
// State encoding and colour-vector helpers for the Simon game controller.
// Colour vectors use a fixed 32-bit maximum width; callers cast to their own width.
package simon_pkg;
  localparam int MAX_COLOURS = 32;
  localparam int IDX_W       = 5;

  typedef enum logic [4:0] {
    S_IDLE, S_SEED, S_ARM, S_START, S_RELEASE, S_ADD, S_SPEED,
    S_SHOW_WAIT, S_SHOW_ON, S_SHOW_OFF, S_INPUT, S_CHECK, S_RELEASE_BTN,
    S_FAIL_ON, S_FAIL_OFF, S_WIN, S_END
  } state_e;

  function automatic logic [MAX_COLOURS-1:0] onehot_of(input logic [IDX_W-1:0] idx);
    return MAX_COLOURS'(1) << idx;
  endfunction

  function automatic logic is_onehot(input logic [MAX_COLOURS-1:0] vec);
    return (vec != '0) && ((vec & (vec - 1'b1)) == '0);
  endfunction
endpackage

// File: rtl/simon_game_ctrl.sv
// Parametrised Simon game controller: launch/seeding, per-round colour append,
// tick-paced sequence replay, press checking with lives, fail flashes and restart.
module simon_game_ctrl
  import simon_pkg::*;
#(
  parameter int NUM_COLOURS   = 4,
  parameter int MAX_ROUNDS    = 32,
  parameter int SPEEDUP_EVERY = 5,
  parameter int NUM_LIVES     = 1,
  parameter int FAIL_FLASHES  = 3,
  parameter int SPEED_W       = 3,
  localparam int CW = ($clog2(NUM_COLOURS) < 1) ? 1 : $clog2(NUM_COLOURS),
  localparam int RW = $clog2(MAX_ROUNDS + 1),
  localparam int LW = $clog2(NUM_LIVES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             launch_keys,
  input  logic [NUM_COLOURS-1:0] player_input,
  input  logic                   tick,
  input  logic [CW-1:0]          seq_colour,
  output logic                   rst_seedgen,
  output logic                   start_rng,
  output logic                   load_colour,
  output logic [RW-1:0]          seq_idx,
  output logic                   load_speed,
  output logic [SPEED_W-1:0]     speed,
  output logic [NUM_COLOURS-1:0] lamp,
  output logic [RW-1:0]          current_round,
  output logic [LW-1:0]          lives_left,
  output logic                   win,
  output logic                   game_over
);

  localparam int FW     = $clog2(FAIL_FLASHES + 1);
  localparam int SE_DIV = (SPEEDUP_EVERY == 0) ? 1 : SPEEDUP_EVERY;

  state_e                 state_q;
  logic [RW-1:0]          round_q, idx_q;
  logic [SPEED_W-1:0]     speed_q;
  logic [LW-1:0]          lives_q;
  logic [FW-1:0]          fail_q;
  logic [NUM_COLOURS-1:0] lamp_q, press_q;
  logic                   win_q, game_over_q;

  logic [NUM_COLOURS-1:0] exp_vec;
  logic [RW-1:0]          round_inc;
  logic [FW-1:0]          fail_d;
  logic                   speedup, good;

  assign exp_vec   = NUM_COLOURS'(onehot_of(IDX_W'(seq_colour)));
  assign round_inc = round_q + 1'b1;
  assign speedup   = (SPEEDUP_EVERY != 0) && ((int'(round_inc) % SE_DIV) == 0);
  assign fail_d    = (fail_q == FW'(FAIL_FLASHES)) ? fail_q : fail_q + 1'b1;
  assign good      = is_onehot(MAX_COLOURS'(press_q)) && (press_q == exp_vec);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      round_q     <= '0;
      idx_q       <= '0;
      speed_q     <= '0;
      lives_q     <= LW'(NUM_LIVES);
      fail_q      <= '0;
      lamp_q      <= '0;
      press_q     <= '0;
      win_q       <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      // Lamp is registered against the next state so it lights in the same cycle the state is entered.
      lamp_q <= '0;
      case (state_q)
        S_IDLE: begin
          round_q     <= '0;
          idx_q       <= '0;
          speed_q     <= '0;
          fail_q      <= '0;
          lives_q     <= LW'(NUM_LIVES);
          win_q       <= 1'b0;
          game_over_q <= 1'b0;
          if (launch_keys[0]) state_q <= S_SEED;
        end
        S_SEED:  state_q <= S_ARM;
        S_ARM:   if (launch_keys == 2'b11) state_q <= S_START;
        S_START: state_q <= S_RELEASE;
        S_RELEASE: begin
          if (launch_keys == 2'b00) begin
            idx_q   <= round_q;
            state_q <= S_ADD;
          end
        end
        S_ADD: begin
          round_q <= round_inc;
          idx_q   <= '0;
          // Speed moves on entry to SPEED so it is already stable while load_speed pulses.
          if (speedup) begin
            if (speed_q != '1) speed_q <= speed_q + 1'b1;
            state_q <= S_SPEED;
          end else begin
            state_q <= S_SHOW_WAIT;
          end
        end
        S_SPEED: state_q <= S_SHOW_WAIT;
        S_SHOW_WAIT: begin
          if (tick) begin
            if (idx_q == round_q) begin
              idx_q   <= '0;
              state_q <= S_INPUT;
            end else begin
              lamp_q  <= exp_vec;
              state_q <= S_SHOW_ON;
            end
          end
        end
        S_SHOW_ON: begin
          if (tick) state_q <= S_SHOW_OFF;
          else      lamp_q  <= exp_vec;
        end
        S_SHOW_OFF: begin
          idx_q   <= idx_q + 1'b1;
          state_q <= S_SHOW_WAIT;
        end
        S_INPUT: begin
          lamp_q <= player_input;
          if (idx_q == round_q) begin
            if (round_q == RW'(MAX_ROUNDS)) begin
              win_q   <= 1'b1;
              state_q <= S_WIN;
            end else begin
              state_q <= S_ADD;
            end
          end else if (|player_input) begin
            press_q <= player_input;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (good) begin
            idx_q   <= idx_q + 1'b1;
            state_q <= S_RELEASE_BTN;
          end else begin
            lives_q <= lives_q - 1'b1;
            fail_q  <= '0;
            lamp_q  <= exp_vec;
            state_q <= S_FAIL_ON;
          end
        end
        S_RELEASE_BTN: if (player_input == '0) state_q <= S_INPUT;
        S_FAIL_ON: begin
          if (tick) state_q <= S_FAIL_OFF;
          else      lamp_q  <= exp_vec;
        end
        S_FAIL_OFF: begin
          if (tick) begin
            fail_q <= fail_d;
            if (fail_d == FW'(FAIL_FLASHES)) begin
              if (player_input == '0) begin
                if (lives_q == '0) begin
                  round_q     <= round_q - 1'b1;
                  game_over_q <= 1'b1;
                  state_q     <= S_END;
                end else begin
                  idx_q   <= '0;
                  state_q <= S_SHOW_WAIT;
                end
              end
            end else begin
              lamp_q  <= exp_vec;
              state_q <= S_FAIL_ON;
            end
          end
        end
        S_WIN: state_q <= S_END;
        S_END: begin
          if (launch_keys == 2'b11) begin
            round_q     <= '0;
            idx_q       <= '0;
            speed_q     <= '0;
            fail_q      <= '0;
            lives_q     <= LW'(NUM_LIVES);
            win_q       <= 1'b0;
            game_over_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rst_seedgen   = (state_q == S_SEED);
  assign start_rng     = (state_q == S_START);
  assign load_colour   = (state_q == S_ADD);
  assign load_speed    = (state_q == S_SPEED);
  assign seq_idx       = idx_q;
  assign speed         = speed_q;
  assign lamp          = lamp_q;
  assign current_round = round_q;
  assign lives_left    = lives_q;
  assign win           = win_q;
  assign game_over     = game_over_q;

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Bench for simon_game_ctrl (4 colours, 3 rounds, speed-up every 2, 2 lives, 3 flashes)
// with a sequence-memory model and a lamp scoreboard.
module tb_simon_game_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] launch_keys;
  logic [3:0] player_input;
  logic       tick;
  logic [1:0] seq_colour;
  logic       rst_seedgen, start_rng, load_colour, load_speed, win, game_over;
  logic [1:0] seq_idx, current_round, lives_left;
  logic [2:0] speed;
  logic [3:0] lamp;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] sb_q[$];
  logic [1:0] plan [0:3];
  logic [1:0] mem  [0:3] = '{default: 2'd0};

  simon_game_ctrl #(
    .NUM_COLOURS(4), .MAX_ROUNDS(3), .SPEEDUP_EVERY(2), .NUM_LIVES(2),
    .FAIL_FLASHES(3), .SPEED_W(3)
  ) dut (
    .clk(clk), .reset(reset), .launch_keys(launch_keys), .player_input(player_input),
    .tick(tick), .seq_colour(seq_colour), .rst_seedgen(rst_seedgen), .start_rng(start_rng),
    .load_colour(load_colour), .seq_idx(seq_idx), .load_speed(load_speed), .speed(speed),
    .lamp(lamp), .current_round(current_round), .lives_left(lives_left), .win(win),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Sequence memory: RNG colour written at seq_idx on load_colour, read combinationally.
  always @(posedge clk) if (load_colour) mem[seq_idx] <= plan[seq_idx];
  assign seq_colour = mem[seq_idx];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; launch_keys = 2'b00; player_input = 4'b0; tick = 1'b0;
    step(); step();
    vectors++;
    if ({rst_seedgen, start_rng, load_colour, load_speed, win, game_over} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 000000",
               {rst_seedgen, start_rng, load_colour, load_speed, win, game_over});
    end
    vectors++;
    if ({seq_idx, current_round, speed, lamp} !== 11'b0) begin
      miscompares++;
      $display("FAIL reset_regs: got %b want 0", {seq_idx, current_round, speed, lamp});
    end
    vectors++;
    if (lives_left !== 2'd2) begin
      miscompares++; $display("FAIL reset_lives: got %0d want 2", lives_left);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_launch();
    launch_keys = 2'b01; step();
    vectors++;
    if ({rst_seedgen, start_rng} !== 2'b10) begin
      miscompares++; $display("FAIL seed_pulse: got %b want 10", {rst_seedgen, start_rng});
    end
    step();
    vectors++;
    if ({rst_seedgen, start_rng} !== 2'b00) begin
      miscompares++; $display("FAIL seed_width: got %b want 00", {rst_seedgen, start_rng});
    end
    launch_keys = 2'b11; step();
    vectors++;
    if ({rst_seedgen, start_rng} !== 2'b01) begin
      miscompares++; $display("FAIL start_pulse: got %b want 01", {rst_seedgen, start_rng});
    end
    step();
    vectors++;
    if (start_rng !== 1'b0) begin
      miscompares++; $display("FAIL start_width: got %b want 0", start_rng);
    end
    launch_keys = 2'b00; step();
    vectors++;
    if ({load_colour, seq_idx} !== 3'b100) begin
      miscompares++; $display("FAIL first_load: got %b want 100", {load_colour, seq_idx});
    end
    step();
    vectors++;
    if ({load_colour, current_round} !== 3'b001) begin
      miscompares++; $display("FAIL round1: got %b want 001", {load_colour, current_round});
    end
  endtask

  task automatic test_show(input int n);
    logic [3:0] e;
    for (int i = 0; i < n; i++) sb_q.push_back(4'b0001 << plan[i]);
    for (int i = 0; i < n; i++) begin
      pulse_tick();
      step();
      e = sb_q.pop_front();
      vectors++;
      if ({load_colour, lamp} !== {1'b0, e}) begin
        miscompares++; $display("FAIL show_lamp[%0d]: got %b want %b", i, {load_colour, lamp}, {1'b0, e});
      end
      pulse_tick();
      vectors++;
      if (lamp !== 4'b0) begin
        miscompares++; $display("FAIL show_gap[%0d]: got %b want 0000", i, lamp);
      end
      step();
    end
    pulse_tick();
    vectors++;
    if ({seq_idx, lamp} !== 6'b0) begin
      miscompares++; $display("FAIL input_entry: got %b want 000000", {seq_idx, lamp});
    end
  endtask

  task automatic press_good(input logic [3:0] v);
    logic [3:0] e;
    player_input = v; sb_q.push_back(v);
    step();
    e = sb_q.pop_front();
    vectors++;
    if (lamp !== e) begin
      miscompares++; $display("FAIL press_echo: got %b want %b", lamp, e);
    end
    step();
    player_input = 4'b0;
    step();
  endtask

  task automatic test_round_presses(input int n);
    for (int i = 0; i < n; i++) press_good(4'b0001 << plan[i]);
  endtask

  task automatic test_next_round(input int new_round);
    logic [2:0] exp_speed;
    logic       exp_ls;
    exp_speed = 3'(new_round / 2);
    exp_ls = (new_round % 2) == 0;
    step();
    vectors++;
    if ({load_colour, seq_idx} !== {1'b1, 2'(new_round - 1)}) begin
      miscompares++;
      $display("FAIL add_load: got %b want %b", {load_colour, seq_idx}, {1'b1, 2'(new_round - 1)});
    end
    step();
    vectors++;
    if ({load_speed, speed, current_round} !== {exp_ls, exp_speed, 2'(new_round)}) begin
      miscompares++;
      $display("FAIL next_round: got %b want %b", {load_speed, speed, current_round},
               {exp_ls, exp_speed, 2'(new_round)});
    end
    if (exp_ls) step();
  endtask

  task automatic test_win();
    step();
    vectors++;
    if ({win, current_round} !== 3'b111) begin
      miscompares++; $display("FAIL win_state: got %b want 111", {win, current_round});
    end
    step(); step(); step();
    vectors++;
    if ({win, game_over, current_round} !== 4'b1011) begin
      miscompares++; $display("FAIL end_hold: got %b want 1011", {win, game_over, current_round});
    end
  endtask

  task automatic test_restart();
    launch_keys = 2'b11; step();
    launch_keys = 2'b00;
    vectors++;
    if ({win, game_over, current_round, seq_idx, speed, lives_left} !== 11'b00000000010) begin
      miscompares++;
      $display("FAIL restart: got %b want 00000000010",
               {win, game_over, current_round, seq_idx, speed, lives_left});
    end
    step();
  endtask

  task automatic test_fail_flashes(input logic [3:0] flash);
    logic [3:0] e;
    for (int f = 0; f < 3; f++) begin
      sb_q.push_back(flash);
      step();
      e = sb_q.pop_front();
      vectors++;
      if (lamp !== e) begin
        miscompares++; $display("FAIL fail_flash[%0d]: got %b want %b", f, lamp, e);
      end
      pulse_tick();
      vectors++;
      if (lamp !== 4'b0) begin
        miscompares++; $display("FAIL fail_gap[%0d]: got %b want 0000", f, lamp);
      end
      pulse_tick();
    end
  endtask

  task automatic test_miss_replay();
    logic [3:0] e;
    player_input = 4'b0010; sb_q.push_back(4'b0010);
    step();
    e = sb_q.pop_front();
    vectors++;
    if (lamp !== e) begin
      miscompares++; $display("FAIL miss_echo: got %b want %b", lamp, e);
    end
    step();
    player_input = 4'b0;
    vectors++;
    if (lives_left !== 2'd1) begin
      miscompares++; $display("FAIL miss_lives: got %0d want 1", lives_left);
    end
    test_fail_flashes(4'b0001 << plan[0]);
    vectors++;
    if ({seq_idx, current_round, lives_left, game_over} !== 7'b0010010) begin
      miscompares++;
      $display("FAIL replay_entry: got %b want 0010010", {seq_idx, current_round, lives_left, game_over});
    end
    test_show(2);
  endtask

  task automatic test_game_over_held();
    logic [3:0] e;
    press_good(4'b0001 << plan[0]);
    player_input = 4'b0101; sb_q.push_back(4'b0101);
    step();
    e = sb_q.pop_front();
    vectors++;
    if (lamp !== e) begin
      miscompares++; $display("FAIL multi_echo: got %b want %b", lamp, e);
    end
    step();
    vectors++;
    if (lives_left !== 2'd0) begin
      miscompares++; $display("FAIL multi_lives: got %0d want 0", lives_left);
    end
    test_fail_flashes(4'b0001 << plan[1]);
    step(); step();
    vectors++;
    if (game_over !== 1'b0) begin
      miscompares++; $display("FAIL held_exit: got %b want 0", game_over);
    end
    player_input = 4'b0;
    step(); step();
    vectors++;
    if (game_over !== 1'b0) begin
      miscompares++; $display("FAIL exit_needs_tick: got %b want 0", game_over);
    end
    pulse_tick();
    vectors++;
    if ({game_over, win, current_round} !== 4'b1001) begin
      miscompares++; $display("FAIL game_over: got %b want 1001", {game_over, win, current_round});
    end
  endtask

  task automatic test_reset_mid_show();
    logic [3:0] e;
    test_launch();
    pulse_tick();
    step();
    e = 4'b0001 << plan[0];
    vectors++;
    if (lamp !== e) begin
      miscompares++; $display("FAIL pre_reset_lamp: got %b want %b", lamp, e);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({lamp, current_round, seq_idx, speed, win, game_over, load_colour} !== 14'b0 ||
        lives_left !== 2'd2) begin
      miscompares++;
      $display("FAIL async_reset: got %b lives %0d want 0 lives 2",
               {lamp, current_round, seq_idx, speed, win, game_over, load_colour}, lives_left);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    plan[0] = 2'd2; plan[1] = 2'd0; plan[2] = 2'd1; plan[3] = 2'd3;
    test_reset();
    // Game 1: three correct rounds to a win.
    test_launch();
    test_show(1);
    test_round_presses(1);
    test_next_round(2);
    test_show(2);
    test_round_presses(2);
    test_next_round(3);
    test_show(3);
    test_round_presses(3);
    test_win();
    test_restart();
    // Game 2: a miss with replay, then a multi-press loss with a held button.
    test_launch();
    test_show(1);
    test_round_presses(1);
    test_next_round(2);
    test_show(2);
    test_miss_replay();
    test_game_over_held();
    test_restart();
    test_reset_mid_show();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
